// File: rtl/grayscale_rgb565_packer.sv
// Grayscale-to-RGB565 expander that packs two pixels per 32-bit word into a small FWFT FIFO.
// Optional: define GRAYSCALE_RGB565_PACKER_SWAP_EN to place the first pixel in [31:16].
module grayscale_rgb565_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pixelValid,
    input  logic [7:0]                    pixelData,
    output logic                          pixelReady,
    input  logic                          flush,
    output logic                          wordValid,
    output logic [31:0]                   wordData,
    input  logic                          wordReady,
    output logic [$clog2(FIFO_DEPTH):0]   fifoLevel,
    output logic                          busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {EMPTY, HALF} state_t;

    state_t          r_state;
    logic [15:0]     r_held;
    logic [31:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;

    logic [15:0]     w_rgb;
    logic            w_accept;
    logic            w_flush;
    logic            w_pop;
    logic            w_push;
    logic [31:0]     w_word;
    logic [31:0]     w_pair;
    logic [31:0]     w_pad_new;
    logic [31:0]     w_pad_held;
    state_t          w_next;

    assign w_rgb      = {pixelData[7:3], pixelData[7:2], pixelData[7:3]};
    assign pixelReady = (r_count < CW'(FIFO_DEPTH));
    assign w_accept   = pixelValid && pixelReady;
    assign w_flush    = flush && pixelReady;
    assign w_pop      = (r_count != '0) && wordReady;

`ifdef GRAYSCALE_RGB565_PACKER_SWAP_EN
    assign w_pair     = {r_held, w_rgb};
    assign w_pad_new  = {w_rgb, 16'h0000};
    assign w_pad_held = {r_held, 16'h0000};
`else
    assign w_pair     = {w_rgb, r_held};
    assign w_pad_new  = {16'h0000, w_rgb};
    assign w_pad_held = {16'h0000, r_held};
`endif

    // A flush arriving with the second pixel is absorbed by the normal pair push.
    always_comb begin
        w_push = 1'b0;
        w_word = '0;
        w_next = r_state;
        if (w_accept) begin
            if (r_state == HALF) begin
                w_push = 1'b1;
                w_word = w_pair;
                w_next = EMPTY;
            end else if (w_flush) begin
                w_push = 1'b1;
                w_word = w_pad_new;
            end else begin
                w_next = HALF;
            end
        end else if (w_flush && r_state == HALF) begin
            w_push = 1'b1;
            w_word = w_pad_held;
            w_next = EMPTY;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= EMPTY;
            r_held  <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && r_state == EMPTY)
                r_held <= w_rgb;
            if (w_push)
                r_wr <= r_wr + PW'(1);
            if (w_pop)
                r_rd <= r_rd + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage needs no reset: an empty FIFO masks wordData to zero.
    always_ff @(posedge clock) begin
        if (!reset && w_push)
            r_mem[r_wr] <= w_word;
    end

    assign wordValid = (r_count != '0);
    assign wordData  = wordValid ? r_mem[r_rd] : 32'h0;
    assign fifoLevel = r_count;
    assign busy      = (r_state == HALF) || (r_count != '0);

endmodule
